// File: rtl/instr_decoder_mac_buf.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decoder_mac_buf (with package cvxif_mac4b_instr_pkg)
//  Purpose  : CV-X-IF issue decoder for the MAC coprocessor. Each offloaded
//             instruction is matched against a CoproInstr table and answered
//             in the same cycle. Accepted instructions wait in an in-order
//             queue until commit. Committed ones are handed to the MAC
//             datapath over valid/ready. Killed ones are dropped.
//  Ports    : clk_i, rst_ni (async, active low), flush_i
//             x_issue_valid_i/x_issue_ready_o/x_issue_req_i/x_issue_resp_o
//             x_commit_valid_i/x_commit_i
//             op_valid_o/op_ready_i, op_idx_o, op_rs_o, op_rd_o, op_id_o,
//             op_we_o, multi_match_o
//  Revision : 1.0 - initial release
// ============================================================================

package cvxif_mac4b_instr_pkg;
  localparam int X_NUM_RS = 2;
  localparam int XLEN     = 32;
  localparam int X_ID_W   = 4;

  typedef logic [X_NUM_RS-1:0][XLEN-1:0] x_rs_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [31:0]         instr;
    x_rs_t               rs;
    logic [X_NUM_RS-1:0] rs_valid;
    logic [X_ID_W-1:0]   id;
  } x_issue_req_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic              x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [31:0]         mask;
    logic [X_NUM_RS-1:0] rs_valid;
    x_issue_resp_t       resp;
  } copro_issue_resp_t;
endpackage

module instr_decoder_mac_buf
  import cvxif_mac4b_instr_pkg::*;
#(
  parameter int                               NbInstr    = 1,
  parameter copro_issue_resp_t [NbInstr-1:0]  CoproInstr = '0,
  parameter int                               FifoDepth  = 4,
  parameter int                               IdxW       = (NbInstr > 1) ? $clog2(NbInstr) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              x_issue_valid_i,
  output logic              x_issue_ready_o,
  input  x_issue_req_t      x_issue_req_i,
  output x_issue_resp_t     x_issue_resp_o,
  input  logic              x_commit_valid_i,
  input  x_commit_t         x_commit_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [IdxW-1:0]   op_idx_o,
  output x_rs_t             op_rs_o,
  output logic [4:0]        op_rd_o,
  output logic [X_ID_W-1:0] op_id_o,
  output logic              op_we_o,
  output logic              multi_match_o
);

  localparam int                 c_ptr_w = $clog2(FifoDepth);
  localparam logic [c_ptr_w:0]   c_depth = FifoDepth[c_ptr_w:0];

  // Queue storage; validity comes from the pointers/count, so the payload
  // itself needs no reset.
  logic [IdxW-1:0]   r_idx  [FifoDepth];
  logic [4:0]        r_rd   [FifoDepth];
  x_rs_t             r_rs   [FifoDepth];
  logic [X_ID_W-1:0] r_id   [FifoDepth];
  logic              r_we   [FifoDepth];
  logic              r_cmt  [FifoDepth];
  logic              r_kill [FifoDepth];

  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w:0]   r_count;

  logic                w_hit;
  logic                w_multi;
  logic [IdxW-1:0]     w_sel;
  x_issue_resp_t       w_resp_sel;
  logic                w_push;
  logic                w_pop;
  logic                w_head_ok;
  logic                w_new_cmt;
  logic [FifoDepth-1:0] w_live;
  logic [c_ptr_w-1:0]  w_off;

  // Table lookup: first hit wins, any later hit flags a multi-match.
  always_comb begin
    w_hit      = 1'b0;
    w_multi    = 1'b0;
    w_sel      = '0;
    w_resp_sel = '0;
    for (int i = 0; i < NbInstr; i++) begin
      if (((CoproInstr[i].mask & x_issue_req_i.instr) == CoproInstr[i].instr) &&
          ((CoproInstr[i].rs_valid & ~x_issue_req_i.rs_valid) == '0)) begin
        if (w_hit) begin
          w_multi = 1'b1;
        end else begin
          w_hit      = 1'b1;
          w_sel      = IdxW'(i);
          w_resp_sel = CoproInstr[i].resp;
        end
      end
    end
  end

  assign x_issue_ready_o = (r_count < c_depth);
  assign x_issue_resp_o  = (x_issue_ready_o && w_hit) ? w_resp_sel : '0;
  assign multi_match_o   = x_issue_valid_i & w_multi;

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    w_live = '0;
    w_off  = '0;
    for (int j = 0; j < FifoDepth; j++) begin
      w_off     = c_ptr_w'(j) - r_rptr;
      w_live[j] = ({1'b0, w_off} < r_count);
    end
  end

  assign w_head_ok = (r_count != '0) & r_cmt[r_rptr];
  assign op_valid_o = w_head_ok & ~r_kill[r_rptr];
  // Killed heads leave without waiting for the datapath.
  assign w_pop  = w_head_ok & (r_kill[r_rptr] | op_ready_i) & ~flush_i;
  assign w_push = x_issue_valid_i & x_issue_resp_o.accept & ~flush_i;
  // A commit arriving alongside the enqueue of the same id lands on the new entry.
  assign w_new_cmt = x_commit_valid_i & (x_commit_i.id == x_issue_req_i.id);

  assign op_idx_o = r_idx[r_rptr];
  assign op_rd_o  = r_rd[r_rptr];
  assign op_rs_o  = r_rs[r_rptr];
  assign op_id_o  = r_id[r_rptr];
  assign op_we_o  = r_we[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < FifoDepth; j++) begin
      if (w_push && (r_wptr == c_ptr_w'(j))) begin
        r_idx[j]  <= w_sel;
        r_rd[j]   <= x_issue_req_i.instr[11:7];
        r_rs[j]   <= x_issue_req_i.rs;
        r_id[j]   <= x_issue_req_i.id;
        r_we[j]   <= x_issue_resp_o.writeback;
        r_cmt[j]  <= w_new_cmt;
        r_kill[j] <= w_new_cmt & x_commit_i.x_commit_kill;
      end else if (!flush_i && x_commit_valid_i && w_live[j] &&
                   (r_id[j] == x_commit_i.id)) begin
        r_cmt[j]  <= 1'b1;
        r_kill[j] <= x_commit_i.x_commit_kill;
      end
    end
  end

`ifndef SYNTHESIS
  a_op_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (op_valid_o && !op_ready_i && !flush_i) |=>
      $stable({op_idx_o, op_rs_o, op_rd_o, op_id_o, op_we_o}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder_mac_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_decoder_mac_buf
//  Purpose  : Self-checking bench for instr_decoder_mac_buf: decode table
//             vectors, directed queue sequences and random traffic compared
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decoder_mac_buf;
  import cvxif_mac4b_instr_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int IW    = 2;

  localparam copro_issue_resp_t E0 = '{instr: 32'h0000000B, mask: 32'hFE00707F, rs_valid: 2'b11,
                                       resp: '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0, exc: 1'b0}};
  localparam copro_issue_resp_t E1 = '{instr: 32'h0000100B, mask: 32'h0000707F, rs_valid: 2'b01,
                                       resp: '{accept: 1'b1, writeback: 1'b0, loadstore: 1'b0, exc: 1'b0}};
  localparam copro_issue_resp_t E2 = '{instr: 32'h0000000B, mask: 32'h0000007F, rs_valid: 2'b00,
                                       resp: '{accept: 1'b1, writeback: 1'b1, loadstore: 1'b0, exc: 1'b0}};
  localparam copro_issue_resp_t E3 = '{instr: 32'h0000005B, mask: 32'h0000007F, rs_valid: 2'b00,
                                       resp: '{accept: 1'b0, writeback: 1'b0, loadstore: 1'b0, exc: 1'b0}};
  localparam copro_issue_resp_t [N-1:0] TABLE = {E3, E2, E1, E0};

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              flush_i;
  logic              x_issue_valid_i;
  logic              x_issue_ready_o;
  x_issue_req_t      x_issue_req_i;
  x_issue_resp_t     x_issue_resp_o;
  logic              x_commit_valid_i;
  x_commit_t         x_commit_i;
  logic              op_valid_o;
  logic              op_ready_i;
  logic [IW-1:0]     op_idx_o;
  x_rs_t             op_rs_o;
  logic [4:0]        op_rd_o;
  logic [X_ID_W-1:0] op_id_o;
  logic              op_we_o;
  logic              multi_match_o;

  instr_decoder_mac_buf #(
    .NbInstr(N), .CoproInstr(TABLE), .FifoDepth(DEPTH), .IdxW(IW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
    .x_issue_req_i(x_issue_req_i), .x_issue_resp_o(x_issue_resp_o),
    .x_commit_valid_i(x_commit_valid_i), .x_commit_i(x_commit_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_idx_o(op_idx_o),
    .op_rs_o(op_rs_o), .op_rd_o(op_rd_o), .op_id_o(op_id_o), .op_we_o(op_we_o),
    .multi_match_o(multi_match_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  idx;
    logic [4:0]  rd;
    x_rs_t       rs;
    logic [3:0]  id;
    logic        we;
    bit          cmt;
    bit          kill;
  } ent_t;
  ent_t q[$];

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  rsv;
    bit          acc;
    bit          wb;
    bit          multi;
  } vec_t;
  vec_t vecs[9];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference decode: count every table hit, remember the first one.
  function automatic void ref_decode(output bit hit, output int sel, output int nmatch);
    hit = 0; sel = 0; nmatch = 0;
    for (int i = 0; i < N; i++) begin
      bit opc_ok = ((x_issue_req_i.instr & TABLE[i].mask) == TABLE[i].instr);
      bit rs_ok  = 1;
      for (int r = 0; r < X_NUM_RS; r++)
        if (TABLE[i].rs_valid[r] && !x_issue_req_i.rs_valid[r]) rs_ok = 0;
      if (opc_ok && rs_ok) begin
        if (nmatch == 0) sel = i;
        nmatch++;
      end
    end
    hit = (nmatch > 0);
  endfunction

  function automatic void model_check();
    bit rdy = (q.size() < DEPTH);
    bit hit; int sel; int nm;
    bit opv;
    chk("issue_ready", x_issue_ready_o, rdy);
    if (x_issue_valid_i) begin
      ref_decode(hit, sel, nm);
      chk("accept", x_issue_resp_o.accept, rdy && hit && TABLE[sel].resp.accept);
      if (rdy) chk("writeback", x_issue_resp_o.writeback, hit && TABLE[sel].resp.writeback);
      chk("multi_match", multi_match_o, nm > 1);
    end else begin
      chk("multi_idle", multi_match_o, 0);
    end
    opv = (q.size() > 0) && q[0].cmt && !q[0].kill;
    chk("op_valid", op_valid_o, opv);
    if (opv) begin
      chk("op_idx", op_idx_o, q[0].idx);
      chk("op_rd", op_rd_o, q[0].rd);
      chk("op_rs", op_rs_o, q[0].rs);
      chk("op_id", op_id_o, q[0].id);
      chk("op_we", op_we_o, q[0].we);
    end
  endfunction

  function automatic void model_update();
    bit hit; int sel; int nm;
    bit pop, push;
    ent_t e;
    if (!rst_ni || flush_i) begin
      q.delete();
      return;
    end
    ref_decode(hit, sel, nm);
    push = x_issue_valid_i && (q.size() < DEPTH) && hit && TABLE[sel].resp.accept;
    pop  = (q.size() > 0) && q[0].cmt && (q[0].kill || op_ready_i);
    if (x_commit_valid_i)
      foreach (q[k]) if (q[k].id == x_commit_i.id) begin
        q[k].cmt  = 1;
        q[k].kill = x_commit_i.x_commit_kill;
      end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.idx  = sel[1:0];
      e.rd   = x_issue_req_i.instr[11:7];
      e.rs   = x_issue_req_i.rs;
      e.id   = x_issue_req_i.id;
      e.we   = TABLE[sel].resp.writeback;
      e.cmt  = x_commit_valid_i && (x_commit_i.id == x_issue_req_i.id);
      e.kill = e.cmt && x_commit_i.x_commit_kill;
      q.push_back(e);
    end
  endfunction

  task automatic cycle();
    @(negedge clk_i);
    model_check();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush_i = 0; x_issue_valid_i = 0; x_issue_req_i = '0;
    x_commit_valid_i = 0; x_commit_i = '0; op_ready_i = 0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [1:0] rsv, input logic [3:0] id);
    x_issue_valid_i        = 1;
    x_issue_req_i.instr    = instr;
    x_issue_req_i.rs_valid = rsv;
    x_issue_req_i.id       = id;
    x_issue_req_i.rs       = {$urandom, $urandom};
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    x_commit_valid_i = 1;
    x_commit_i.id = id;
    x_commit_i.x_commit_kill = kill;
  endtask

  localparam logic [31:0] MAC = 32'h0000058B;  // entry 0 form, rd = 11

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{MAC,          2'b11, 1, 1, 1};
    vecs[1] = '{MAC,          2'b01, 1, 1, 0};
    vecs[2] = '{32'h0000100B, 2'b01, 1, 0, 1};
    vecs[3] = '{32'h0000100B, 2'b00, 1, 1, 0};
    vecs[4] = '{32'h0000100B, 2'b10, 1, 1, 0};
    vecs[5] = '{32'h00000013, 2'b11, 0, 0, 0};
    vecs[6] = '{32'h0000005B, 2'b11, 0, 0, 0};
    vecs[7] = '{32'h0200000B, 2'b11, 1, 1, 0};
    vecs[8] = '{32'h0000002B, 2'b11, 0, 0, 0};

    idle();
    #1 rst_ni = 0;
    #1;
    chk("rst_ready", x_issue_ready_o, 1);
    chk("rst_op_valid", op_valid_o, 0);
    chk("rst_multi", multi_match_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;

    // Decode table; flush keeps the queue empty while only the response is observed.
    for (int v = 0; v < 9; v++) begin
      idle();
      flush_i = 1;
      issue(vecs[v].instr, vecs[v].rsv, 4'(v));
      #1;
      chk("vec_accept", x_issue_resp_o.accept, vecs[v].acc);
      chk("vec_writeback", x_issue_resp_o.writeback, vecs[v].wb);
      chk("vec_multi", multi_match_o, vecs[v].multi);
      cycle();
    end

    // T1 single op
    idle(); issue(MAC, 2'b11, 3); #1;
    chk("t1_accept", x_issue_resp_o.accept, 1);
    cycle();
    idle(); commit(3, 0); #1;
    chk("t1_no_early_valid", op_valid_o, 0);
    cycle();
    idle(); #1;
    chk("t1_op_valid", op_valid_o, 1);
    chk("t1_op_idx", op_idx_o, 0);
    chk("t1_op_rd", op_rd_o, 5'd11);
    chk("t1_op_id", op_id_o, 3);
    op_ready_i = 1; cycle();
    idle(); #1; chk("t1_drained", op_valid_o, 0);

    // T2 unknown opcode
    idle(); issue(32'h00000013, 2'b11, 1); #1;
    chk("t2_accept", x_issue_resp_o.accept, 0);
    chk("t2_writeback", x_issue_resp_o.writeback, 0);
    cycle();
    idle(); commit(1, 0); cycle();
    idle(); #1;
    chk("t2_op_valid", op_valid_o, 0);
    chk("t2_ready", x_issue_ready_o, 1);

    // T3 fill
    for (int i = 0; i < 4; i++) begin idle(); issue(MAC, 2'b11, 4'(i)); cycle(); end
    idle(); #1; chk("t3_full_ready", x_issue_ready_o, 0);
    issue(MAC, 2'b11, 7); #1; chk("t3_full_accept", x_issue_resp_o.accept, 0);
    cycle();
    idle(); commit(0, 0); op_ready_i = 1; cycle();
    idle(); op_ready_i = 1; #1; chk("t3_still_full", x_issue_ready_o, 0);
    issue(MAC, 2'b11, 9); #1; chk("t3_full_pop_accept", x_issue_resp_o.accept, 0);
    cycle();
    idle(); #1; chk("t3_ready_back", x_issue_ready_o, 1);
    flush_i = 1; cycle();

    // T4 kill
    idle(); issue(MAC, 2'b11, 5); cycle();
    idle(); issue(MAC, 2'b11, 6); cycle();
    idle(); commit(5, 1); cycle();
    idle(); commit(6, 0); #1; chk("t4_killed_silent", op_valid_o, 0);
    cycle();
    idle(); #1;
    chk("t4_op_valid", op_valid_o, 1);
    chk("t4_op_id", op_id_o, 6);
    op_ready_i = 1; cycle();
    idle(); #1; chk("t4_empty", op_valid_o, 0);

    // T5 out-of-order commit with backpressure
    idle(); issue(MAC, 2'b11, 1); cycle();
    idle(); issue(32'h0000100B, 2'b11, 2); cycle();
    idle(); commit(2, 0); #1; chk("t5_wait_head", op_valid_o, 0);
    cycle();
    idle(); commit(1, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); #1;
      chk("t5_hold_valid", op_valid_o, 1);
      chk("t5_hold_id", op_id_o, 1);
      cycle();
    end
    idle(); op_ready_i = 1; cycle();
    idle(); op_ready_i = 1; #1;
    chk("t5_second_id", op_id_o, 2);
    chk("t5_second_idx", op_idx_o, 1);
    cycle();
    idle(); #1; chk("t5_empty", op_valid_o, 0);

    // T6 flush, then reset mid-stream
    for (int i = 0; i < 3; i++) begin idle(); issue(MAC, 2'b11, 4'(8 + i)); cycle(); end
    idle(); commit(8, 0); cycle();
    idle(); flush_i = 1; cycle();
    idle(); #1;
    chk("t6_flush_ready", x_issue_ready_o, 1);
    chk("t6_flush_valid", op_valid_o, 0);
    commit(9, 0); cycle();
    idle(); #1; chk("t6_flush_stale", op_valid_o, 0);
    for (int i = 0; i < 3; i++) begin idle(); issue(MAC, 2'b11, 4'(8 + i)); cycle(); end
    idle(); commit(8, 0); cycle();
    idle(); #1; chk("t6_pre_reset_valid", op_valid_o, 1);
    #1 rst_ni = 0;
    q.delete();
    #1;
    chk("t6_rst_valid", op_valid_o, 0);
    chk("t6_rst_ready", x_issue_ready_o, 1);
    cycle();
    rst_ni = 1;
    idle(); commit(9, 0); cycle();
    idle(); commit(8, 0); cycle();
    idle(); #1; chk("t6_rst_stale", op_valid_o, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] ins;
      idle();
      r = int'($urandom % 5);
      if (r < 4) ins = TABLE[r].instr | ($urandom & ~TABLE[r].mask);
      else       ins = $urandom;
      if ($urandom % 2 == 0) issue(ins, 2'($urandom), 4'($urandom));
      if ($urandom % 2 == 0) begin
        if (q.size() > 0 && ($urandom % 3 != 0))
          commit(q[$urandom % q.size()].id, ($urandom % 4) == 0);
        else
          commit(4'($urandom), ($urandom % 4) == 0);
      end
      op_ready_i = ($urandom % 3) != 0;
      flush_i    = ($urandom % 64) == 0;
      cycle();
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
